// File: rtl/io_port_bridge_pkg.sv
// Shared constants and FSM encodings for the CPU I/O port bridge.
package io_bridge_pkg;

    localparam int DEF_DW    = 32;
    localparam int DEF_DEPTH = 4;

    typedef enum logic [1:0] {
        OUT_IDLE = 2'd0,
        OUT_REQ  = 2'd1,
        OUT_REL  = 2'd2
    } out_state_e;

    typedef enum logic {
        IN_IDLE = 1'b0,
        IN_ACK  = 1'b1
    } in_state_e;

endpackage

// File: rtl/io_port_bridge_if.sv
// CPU-side and device-side signal bundle of the I/O port bridge.
interface io_port_bridge_if #(
    parameter int DW = io_bridge_pkg::DEF_DW
);
    logic          cpu_wr_en;
    logic [DW-1:0] cpu_wr_data;
    logic          cpu_wr_full;
    logic          cpu_rd_en;
    logic [DW-1:0] cpu_rd_data;
    logic          cpu_rd_valid;
    logic          dev_out_req;
    logic [DW-1:0] dev_out_data;
    logic          dev_out_ack;
    logic          dev_in_req;
    logic [DW-1:0] dev_in_data;
    logic          dev_in_ack;

    modport slave (
        input  cpu_wr_en, cpu_wr_data, cpu_rd_en, dev_out_ack, dev_in_req, dev_in_data,
        output cpu_wr_full, cpu_rd_data, cpu_rd_valid, dev_out_req, dev_out_data, dev_in_ack
    );

    modport master (
        output cpu_wr_en, cpu_wr_data, cpu_rd_en, dev_out_ack, dev_in_req, dev_in_data,
        input  cpu_wr_full, cpu_rd_data, cpu_rd_valid, dev_out_req, dev_out_data, dev_in_ack
    );
endinterface

// File: rtl/io_port_bridge_fifo.sv
// Small synchronous FIFO; writes while full and reads while empty are ignored.
module io_fifo #(
    parameter int DW    = 32,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          wr_en_i,
    input  logic [DW-1:0] wr_data_i,
    input  logic          rd_en_i,
    output logic [DW-1:0] rd_data_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW:0]   count_o
);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          wr_ok, rd_ok;

    // Full/empty come from the registered count, so a pop never frees space the same cycle.
    assign full_o    = (count_q == FULL_CNT);
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign rd_data_o = mem_q[rd_ptr_q];
    assign wr_ok     = wr_en_i && !full_o;
    assign rd_ok     = rd_en_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (rd_ok) rd_ptr_d = rd_ptr_q + AW'(1);
        case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_ok) mem_q[wr_ptr_q] <= wr_data_i;
    end

endmodule

// File: rtl/io_port_bridge.sv
// Device-side end of the CPU I/O port: buffered four-phase output path and held input path.
module io_port_bridge
    import io_bridge_pkg::*;
#(
    parameter int DW    = DEF_DW,
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = 2
) (
    input  logic            CLK,
    input  logic            RST_n,
    io_port_bridge_if.slave bus
);
    logic          ack_meta_q, ack_s_q;
    logic          req_meta_q, req_s_q;

    logic [DW-1:0] fifo_rd_data;
    logic          fifo_full, fifo_empty, fifo_pop;
    logic [AW:0]   fifo_count_unused;

    out_state_e    out_state_q, out_state_d;
    logic          out_req_q, out_req_d;
    logic [DW-1:0] out_data_q, out_data_d;

    in_state_e     in_state_q, in_state_d;
    logic          in_ack_q, in_ack_d;
    logic          rd_valid_q, rd_valid_d;
    logic [DW-1:0] rd_data_q, rd_data_d;

    io_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk_i     (CLK),
        .rst_ni    (RST_n),
        .wr_en_i   (bus.cpu_wr_en),
        .wr_data_i (bus.cpu_wr_data),
        .rd_en_i   (fifo_pop),
        .rd_data_o (fifo_rd_data),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .count_o   (fifo_count_unused)
    );

    // Two-flop synchronisers for the device handshake inputs, which are asynchronous to CLK.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            ack_meta_q <= 1'b0;
            ack_s_q    <= 1'b0;
            req_meta_q <= 1'b0;
            req_s_q    <= 1'b0;
        end else begin
            ack_meta_q <= bus.dev_out_ack;
            ack_s_q    <= ack_meta_q;
            req_meta_q <= bus.dev_in_req;
            req_s_q    <= req_meta_q;
        end
    end

    always_comb begin
        out_state_d = out_state_q;
        out_req_d   = out_req_q;
        out_data_d  = out_data_q;
        fifo_pop    = 1'b0;
        case (out_state_q)
            OUT_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop    = 1'b1;
                    out_data_d  = fifo_rd_data;
                    out_req_d   = 1'b1;
                    out_state_d = OUT_REQ;
                end
            end
            OUT_REQ: begin
                if (ack_s_q) begin
                    out_req_d   = 1'b0;
                    out_state_d = OUT_REL;
                end
            end
            OUT_REL: begin
                if (!ack_s_q) out_state_d = OUT_IDLE;
            end
            default: begin
                out_req_d   = 1'b0;
                out_state_d = OUT_IDLE;
            end
        endcase
    end

    // Capture decisions use the pre-read valid, so a read and a capture never share a cycle.
    always_comb begin
        in_state_d = in_state_q;
        in_ack_d   = in_ack_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_valid_q;
        if (bus.cpu_rd_en && rd_valid_q) rd_valid_d = 1'b0;
        case (in_state_q)
            IN_IDLE: begin
                if (req_s_q && !rd_valid_q) begin
                    rd_data_d  = bus.dev_in_data;
                    rd_valid_d = 1'b1;
                    in_ack_d   = 1'b1;
                    in_state_d = IN_ACK;
                end
            end
            IN_ACK: begin
                if (!req_s_q) begin
                    in_ack_d   = 1'b0;
                    in_state_d = IN_IDLE;
                end
            end
            default: begin
                in_ack_d   = 1'b0;
                in_state_d = IN_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            out_state_q <= OUT_IDLE;
            out_req_q   <= 1'b0;
            out_data_q  <= '0;
            in_state_q  <= IN_IDLE;
            in_ack_q    <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            out_state_q <= out_state_d;
            out_req_q   <= out_req_d;
            out_data_q  <= out_data_d;
            in_state_q  <= in_state_d;
            in_ack_q    <= in_ack_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
        end
    end

    assign bus.cpu_wr_full  = fifo_full;
    assign bus.cpu_rd_data  = rd_data_q;
    assign bus.cpu_rd_valid = rd_valid_q;
    assign bus.dev_out_req  = out_req_q;
    assign bus.dev_out_data = out_data_q;
    assign bus.dev_in_ack   = in_ack_q;

endmodule

// File: tb/tb_io_port_bridge.sv
// Directed self-checking bench for io_port_bridge.
module tb_io_port_bridge;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic auto_en = 1'b0;
    logic model_ack = 1'b0;
    logic man_ack = 1'b0;
    logic [31:0] rx_q[$];
    int pass_cnt = 0;
    int total_cnt = 0;

    io_port_bridge_if #(.DW(32)) bus ();

    io_port_bridge #(.DW(32), .DEPTH(4), .AW(2)) dut (
        .CLK   (clk),
        .RST_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign bus.dev_out_ack = auto_en ? model_ack : man_ack;

    // Auto-acking output device: takes the word on req, then completes the four-phase cycle.
    always @(negedge clk) begin
        if (!auto_en) begin
            model_ack = 1'b0;
        end else if (bus.dev_out_req && !model_ack) begin
            rx_q.push_back(bus.dev_out_data);
            $display("device rx word %h", bus.dev_out_data);
            model_ack = 1'b1;
        end else if (!bus.dev_out_req && model_ack) begin
            model_ack = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic cpu_write(input logic [31:0] d);
        bus.cpu_wr_en   = 1'b1;
        bus.cpu_wr_data = d;
        tick();
        bus.cpu_wr_en   = 1'b0;
        $display("cpu write %h", d);
    endtask

    task automatic do_reset();
        auto_en = 1'b0;
        man_ack = 1'b0;
        bus.cpu_wr_en = 1'b0;
        bus.cpu_wr_data = '0;
        bus.cpu_rd_en = 1'b0;
        bus.dev_in_req = 1'b0;
        bus.dev_in_data = '0;
        rst_n = 1'b0;
        ticks(2);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        total_cnt++; if ({bus.dev_out_req, bus.dev_in_ack, bus.cpu_rd_valid, bus.cpu_wr_full} !== 4'b0) $display("FAIL reset_ctrl got %b expected 0000", {bus.dev_out_req, bus.dev_in_ack, bus.cpu_rd_valid, bus.cpu_wr_full}); else pass_cnt++;
        total_cnt++; if ({bus.dev_out_data, bus.cpu_rd_data} !== 64'h0) $display("FAIL reset_data got %h expected 0", {bus.dev_out_data, bus.cpu_rd_data}); else pass_cnt++;
        cpu_write(32'h77);
        cpu_write(32'h78);
        cpu_write(32'h79);
        total_cnt++; if (bus.dev_out_req !== 1'b1 || bus.dev_out_data !== 32'h77) $display("FAIL pre_reset_req got %b/%h expected 1/00000077", bus.dev_out_req, bus.dev_out_data); else pass_cnt++;
        rst_n = 1'b0;
        #1;
        total_cnt++; if (bus.dev_out_req !== 1'b0 || bus.dev_out_data !== 32'h0) $display("FAIL async_reset got %b/%h expected 0/00000000", bus.dev_out_req, bus.dev_out_data); else pass_cnt++;
        tick();
        rst_n = 1'b1;
        ticks(5);
        total_cnt++; if (bus.dev_out_req !== 1'b0 || bus.cpu_wr_full !== 1'b0) $display("FAIL reset_flush got req=%b full=%b expected 0/0", bus.dev_out_req, bus.cpu_wr_full); else pass_cnt++;
        $display("reset test done");
    endtask

    task automatic test_single_output();
        do_reset();
        cpu_write(32'hDEADBEEF);
        total_cnt++; if (bus.dev_out_req !== 1'b0) $display("FAIL req_on_write_edge got %b expected 0", bus.dev_out_req); else pass_cnt++;
        tick();
        total_cnt++; if (bus.dev_out_req !== 1'b1 || bus.dev_out_data !== 32'hDEADBEEF) $display("FAIL single_req got %b/%h expected 1/deadbeef", bus.dev_out_req, bus.dev_out_data); else pass_cnt++;
        ticks(3);
        man_ack = 1'b1;
        ticks(2);
        total_cnt++; if (bus.dev_out_req !== 1'b1) $display("FAIL req_held_sync got %b expected 1", bus.dev_out_req); else pass_cnt++;
        tick();
        total_cnt++; if (bus.dev_out_req !== 1'b0) $display("FAIL req_fall got %b expected 0", bus.dev_out_req); else pass_cnt++;
        man_ack = 1'b0;
        ticks(4);
        total_cnt++; if (bus.dev_out_req !== 1'b0 || bus.dev_out_data !== 32'hDEADBEEF) $display("FAIL out_idle got %b/%h expected 0/deadbeef", bus.dev_out_req, bus.dev_out_data); else pass_cnt++;
        $display("single output done");
    endtask

    task automatic test_overflow();
        logic [31:0] got;
        do_reset();
        rx_q.delete();
        for (int i = 1; i <= 6; i++) begin
            bus.cpu_wr_en = 1'b1;
            bus.cpu_wr_data = 32'(i);
            tick();
        end
        bus.cpu_wr_en = 1'b0;
        total_cnt++; if (bus.cpu_wr_full !== 1'b1) $display("FAIL full_flag got %b expected 1", bus.cpu_wr_full); else pass_cnt++;
        total_cnt++; if (bus.dev_out_req !== 1'b1 || bus.dev_out_data !== 32'h1) $display("FAIL inflight got %b/%h expected 1/00000001", bus.dev_out_req, bus.dev_out_data); else pass_cnt++;
        auto_en = 1'b1;
        for (int c = 0; c < 400 && rx_q.size() < 5; c++) tick();
        ticks(30);
        total_cnt++; if (rx_q.size() !== 5) $display("FAIL overflow_count got %0d expected 5", rx_q.size()); else pass_cnt++;
        for (int i = 0; i < 5; i++) begin
            got = (i < rx_q.size()) ? rx_q[i] : 32'hFFFF_FFFF;
            total_cnt++; if (got !== 32'(i + 1)) $display("FAIL overflow_word%0d got %h expected %h", i, got, 32'(i + 1)); else pass_cnt++;
        end
        total_cnt++; if (bus.cpu_wr_full !== 1'b0) $display("FAIL full_clear got %b expected 0", bus.cpu_wr_full); else pass_cnt++;
    endtask

    task automatic test_wrap();
        logic [31:0] got;
        do_reset();
        rx_q.delete();
        auto_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            for (int c = 0; c < 200 && bus.cpu_wr_full; c++) tick();
            cpu_write(32'h10 + 32'(i));
            ticks(i % 3);
        end
        for (int c = 0; c < 800 && rx_q.size() < 10; c++) tick();
        ticks(30);
        total_cnt++; if (rx_q.size() !== 10) $display("FAIL wrap_count got %0d expected 10", rx_q.size()); else pass_cnt++;
        for (int i = 0; i < 10; i++) begin
            got = (i < rx_q.size()) ? rx_q[i] : 32'hFFFF_FFFF;
            total_cnt++; if (got !== 32'h10 + 32'(i)) $display("FAIL wrap_word%0d got %h expected %h", i, got, 32'h10 + 32'(i)); else pass_cnt++;
        end
        auto_en = 1'b0;
    endtask

    task automatic test_input();
        do_reset();
        bus.dev_in_data = 32'hA5A5_0001;
        bus.dev_in_req = 1'b1;
        ticks(2);
        total_cnt++; if (bus.dev_in_ack !== 1'b0 || bus.cpu_rd_valid !== 1'b0) $display("FAIL in_early got ack=%b valid=%b expected 0/0", bus.dev_in_ack, bus.cpu_rd_valid); else pass_cnt++;
        tick();
        total_cnt++; if (bus.dev_in_ack !== 1'b1 || bus.cpu_rd_valid !== 1'b1) $display("FAIL in_capture got ack=%b valid=%b expected 1/1", bus.dev_in_ack, bus.cpu_rd_valid); else pass_cnt++;
        total_cnt++; if (bus.cpu_rd_data !== 32'hA5A5_0001) $display("FAIL in_data got %h expected a5a50001", bus.cpu_rd_data); else pass_cnt++;
        bus.dev_in_req = 1'b0;
        ticks(2);
        total_cnt++; if (bus.dev_in_ack !== 1'b1) $display("FAIL in_ack_hold got %b expected 1", bus.dev_in_ack); else pass_cnt++;
        tick();
        total_cnt++; if (bus.dev_in_ack !== 1'b0) $display("FAIL in_ack_drop got %b expected 0", bus.dev_in_ack); else pass_cnt++;
        $display("input word received %h", bus.cpu_rd_data);
    endtask

    task automatic test_input_backpressure();
        bus.dev_in_data = 32'h2;
        bus.dev_in_req = 1'b1;
        ticks(6);
        total_cnt++; if (bus.dev_in_ack !== 1'b0 || bus.cpu_rd_data !== 32'hA5A5_0001) $display("FAIL bp_stall got ack=%b data=%h expected 0/a5a50001", bus.dev_in_ack, bus.cpu_rd_data); else pass_cnt++;
        bus.cpu_rd_en = 1'b1;
        tick();
        bus.cpu_rd_en = 1'b0;
        total_cnt++; if (bus.cpu_rd_valid !== 1'b0 || bus.dev_in_ack !== 1'b0 || bus.cpu_rd_data !== 32'hA5A5_0001) $display("FAIL bp_read got valid=%b ack=%b data=%h expected 0/0/a5a50001", bus.cpu_rd_valid, bus.dev_in_ack, bus.cpu_rd_data); else pass_cnt++;
        tick();
        total_cnt++; if (bus.cpu_rd_valid !== 1'b1 || bus.dev_in_ack !== 1'b1 || bus.cpu_rd_data !== 32'h2) $display("FAIL bp_capture got valid=%b ack=%b data=%h expected 1/1/00000002", bus.cpu_rd_valid, bus.dev_in_ack, bus.cpu_rd_data); else pass_cnt++;
        bus.dev_in_req = 1'b0;
        ticks(3);
        bus.cpu_rd_en = 1'b1;
        tick();
        bus.cpu_rd_en = 1'b0;
        total_cnt++; if (bus.cpu_rd_valid !== 1'b0 || bus.dev_in_ack !== 1'b0) $display("FAIL bp_final got valid=%b ack=%b expected 0/0", bus.cpu_rd_valid, bus.dev_in_ack); else pass_cnt++;
        $display("input word received %h", bus.cpu_rd_data);
    endtask

    initial begin
        test_reset();
        test_single_output();
        test_overflow();
        test_wrap();
        test_input();
        test_input_backpressure();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
